// File: rtl/dr_uart_reporter_pkg.sv
// Shared constants and helpers for the dr UART reporter.
// Holds the FSM encoding, the ASCII terminators and the hex encoder.
package dr_uart_reporter_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [3:0] MSG_BYTES = 4'd10;

    typedef enum logic [1:0] {
        DRTX_IDLE,
        DRTX_SEND,
        DRTX_DONE
    } drtx_state_e;

    // Byte k of the message: eight hex digits MSB first, then CR LF.
    function automatic logic [7:0] msg_byte(
        input logic [31:0] v,
        input logic [3:0]  k
    );
        logic [31:0] sh;
        logic [3:0]  n;
        sh = v << {k[2:0], 2'b00};
        n  = sh[31:28];
        if (k == 4'd8)
            return ASCII_CR;
        else if (k == 4'd9)
            return ASCII_LF;
        else if (n < 4'd10)
            return 8'h30 + {4'd0, n};
        else
            return 8'h37 + {4'd0, n};
    endfunction

endpackage

// File: rtl/dr_uart_reporter_uart_tx_byte.sv
// 8N1 byte transmitter with a per-bit baud counter.
// Ready also rises on the last stop-bit count so bytes chain gap-free.
module uart_tx_byte #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd
);

    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

    logic        active;
    logic [15:0] cnt;
    logic [3:0]  left;
    logic [8:0]  shreg;
    logic        tick;
    logic        fin;

    assign tick  = active && (cnt == LAST);
    assign fin   = tick && (left == 4'd0);
    assign ready = !active || fin;

    always_ff @(posedge clk) begin
        if (!reset) begin
            active <= 1'b0;
            cnt    <= '0;
            left   <= '0;
            shreg  <= '1;
            txd    <= 1'b1;
        end else if (valid && ready) begin
            active <= 1'b1;
            cnt    <= '0;
            left   <= 4'd9;
            shreg  <= {1'b1, data};
            txd    <= 1'b0;
        end else if (fin) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (tick) begin
            cnt   <= '0;
            left  <= left - 4'd1;
            txd   <= shreg[0];
            shreg <= {1'b1, shreg[8:1]};
        end else if (active) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/dr_uart_reporter.sv
// Watches the CPU debug register and streams each new value as hex text.
// One-slot pending buffer keeps the latest value seen while busy.
module dr_uart_reporter
    import dr_uart_reporter_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dr,
    input  logic        resend,
    output logic        txd,
    output logic        busy,
    output logic        overrun
);

    drtx_state_e state;
    drtx_state_e state_n;
    logic [3:0]  idx;
    logic [31:0] snapshot;
    logic [31:0] last_sent;
    logic [31:0] pending;
    logic        pending_valid;
    logic        trigger;
    logic        load;
    logic [31:0] load_val;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    assign trigger = (dr != last_sent) || resend;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .valid (tx_valid),
        .ready (tx_ready),
        .txd   (txd)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= DRTX_IDLE;
        else
            state <= state_n;
    end

    // IDLE and DONE hand byte 0 straight to the transmitter as they load.
    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        load     = 1'b0;
        load_val = dr;
        tx_data  = msg_byte(snapshot, idx);
        unique case (state)
            DRTX_IDLE: begin
                if (trigger) begin
                    tx_valid = 1'b1;
                    load     = 1'b1;
                    state_n  = DRTX_SEND;
                end
            end
            DRTX_SEND: begin
                if (idx == MSG_BYTES) begin
                    if (tx_ready)
                        state_n = DRTX_DONE;
                end else begin
                    tx_valid = 1'b1;
                end
            end
            DRTX_DONE: begin
                if (!trigger)
                    load_val = pending;
                if (trigger || pending_valid) begin
                    tx_valid = 1'b1;
                    load     = 1'b1;
                    state_n  = DRTX_SEND;
                end else begin
                    state_n = DRTX_IDLE;
                end
            end
            default: state_n = DRTX_IDLE;
        endcase
        if (load)
            tx_data = msg_byte(load_val, 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx           <= '0;
            snapshot      <= '0;
            last_sent     <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (trigger)
                last_sent <= dr;
            if (load) begin
                snapshot <= load_val;
                idx      <= 4'd1;
                busy     <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                idx <= idx + 4'd1;
            end
            if (state == DRTX_SEND && trigger) begin
                pending       <= dr;
                pending_valid <= 1'b1;
            end else if (load && state == DRTX_DONE) begin
                pending_valid <= 1'b0;
            end
            if (state != DRTX_IDLE && trigger && pending_valid)
                overrun <= 1'b1;
            if (state == DRTX_DONE && !load)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dr_uart_reporter.sv
// Bench for dr_uart_reporter: message-level reference model checked
// every cycle, table-driven message decode, and directed corner cases.
module tb_dr_uart_reporter;

    localparam int B   = 4;
    localparam int MSG = 100 * B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        resend = 1'b0;
    logic [31:0] dr = '0;
    logic        txd;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad = 0;

    dr_uart_reporter #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .reset   (reset),
        .dr      (dr),
        .resend  (resend),
        .txd     (txd),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: message start times plus pending slot.
    string       hexs = "0123456789ABCDEF";
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_tleft = 0;
    int          m_start = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_last = '0;
    logic [31:0] m_pend = '0;
    bit          m_pv = 0;
    bit          m_ovr = 0;
    bit          chk_on = 0;

    function automatic logic [7:0] msg_char(input logic [31:0] v, input int k);
        if (k == 8) return 8'h0D;
        if (k == 9) return 8'h0A;
        return hexs[int'((v >> (28 - 4 * k)) & 32'hF)];
    endfunction

    function automatic logic exp_txd();
        int o, k, j;
        logic [7:0] ch;
        o = cyc - m_start;
        if (!m_busy || o >= MSG) return 1'b1;
        k = o / (10 * B);
        j = (o % (10 * B)) / B;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        ch = msg_char(m_val, k);
        return ch[j-1];
    endfunction

    function automatic void m_begin(input logic [31:0] v);
        m_busy  = 1;
        m_tleft = MSG;
        m_start = cyc;
        m_val   = v;
    endfunction

    always @(posedge clk) begin
        bit trig;
        cyc++;
        if (!reset) begin
            m_busy = 0; m_tleft = 0; m_last = '0;
            m_pv = 0; m_ovr = 0;
        end else begin
            trig = (dr != m_last) || resend;
            if (!m_busy) begin
                if (trig) m_begin(dr);
            end else if (m_tleft > 0) begin
                m_tleft--;
                if (trig) begin
                    if (m_pv) m_ovr = 1;
                    m_pend = dr;
                    m_pv = 1;
                end
            end else begin
                if (trig) begin
                    if (m_pv) m_ovr = 1;
                    m_begin(dr);
                    m_pv = 0;
                end else if (m_pv) begin
                    m_begin(m_pend);
                    m_pv = 0;
                end else begin
                    m_busy = 0;
                end
            end
            if (trig) m_last = dr;
        end
    end

    always @(negedge clk) begin
        logic e;
        if (chk_on) begin
            e = exp_txd();
            total++;
            if (txd !== e || busy !== m_busy || overrun !== m_ovr) begin
                bad++;
                $display("FAIL model cyc=%0d txd/busy/ovr got %b%b%b want %b%b%b",
                         cyc, txd, busy, overrun, e, m_busy, m_ovr);
            end
        end
    end

    task automatic check(input string name, input logic [79:0] got,
                         input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_msg(input int limit, output logic [79:0] got,
                          output int lat, output bit ok);
        logic [7:0] ch;
        int j;
        got = '0; lat = 0; ok = 1; ch = '0;
        while (txd !== 1'b0 && lat < limit) begin
            step();
            lat++;
        end
        if (txd !== 1'b0) begin
            ok = 0;
            return;
        end
        for (int o = 0; o < MSG; o++) begin
            if (o % B == B / 2) begin
                j = (o / B) % 10;
                if (j == 0) begin
                    if (txd !== 1'b0) ok = 0;
                end else if (j == 9) begin
                    if (txd !== 1'b1) ok = 0;
                    got = {got[71:0], ch};
                end else begin
                    ch[j-1] = txd;
                end
            end
            if (o != MSG - 1) step();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3 * MSG) begin
            step();
            n++;
        end
        check("idle_wait", {79'd0, busy}, 80'd0);
    endtask

    typedef struct {
        logic [31:0] val;
        logic [63:0] text;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [79:0] got;
        int          lat;
        bit          ok;
        int          lows;

        tbl[0] = '{32'h1234ABCD, "1234ABCD"};
        tbl[1] = '{32'hCAFE0009, "CAFE0009"};
        tbl[2] = '{32'h0000FFFF, "0000FFFF"};
        tbl[3] = '{32'h89ABCDEF, "89ABCDEF"};

        @(posedge clk);
        #1 chk_on = 1;
        step();
        step();
        reset = 1'b1;

        lows = 0;
        repeat (500) begin
            step();
            if (txd !== 1'b1) lows++;
        end
        check("idle_no_start", 80'(lows), 80'd0);
        check("idle_busy", {79'd0, busy}, 80'd0);

        for (int i = 0; i < 4; i++) begin
            dr = tbl[i].val;
            rx_msg(5, got, lat, ok);
            check("tbl_latency", 80'(lat), 80'd1);
            check("tbl_frame", {79'd0, ok}, 80'd1);
            check("tbl_text", got, {tbl[i].text, 8'h0D, 8'h0A});
            step();
            check("tbl_done_busy", {79'd0, busy}, 80'd1);
            step();
            check("tbl_busy_fall", {79'd0, busy}, 80'd0);
            repeat (3) step();
        end

        dr = 32'hDEADBEEF;
        rx_msg(5, got, lat, ok);
        check("beef_text", got, {"DEADBEEF", 8'h0D, 8'h0A});
        repeat (10) step();
        check("beef_idle", {79'd0, busy}, 80'd0);
        resend = 1'b1;
        step();
        resend = 1'b0;
        rx_msg(5, got, lat, ok);
        check("resend_latency", 80'(lat), 80'd0);
        check("resend_text", got, {"DEADBEEF", 8'h0D, 8'h0A});
        check("resend_ovr", {79'd0, overrun}, 80'd0);
        wait_idle();

        dr = 32'h00C0FFEE;
        rx_msg(5, got, lat, ok);
        check("pre_done_text", got, {"00C0FFEE", 8'h0D, 8'h0A});
        step();
        check("done_cycle_busy", {79'd0, busy}, 80'd1);
        dr = 32'h7777FACE;
        rx_msg(3, got, lat, ok);
        check("done_chg_latency", 80'(lat), 80'd1);
        check("done_chg_text", got, {"7777FACE", 8'h0D, 8'h0A});
        check("done_chg_ovr", {79'd0, overrun}, 80'd0);
        wait_idle();

        dr = 32'h00000001;
        fork
            rx_msg(5, got, lat, ok);
            begin
                repeat (50) step();
                dr = 32'h2;
                repeat (20) step();
                dr = 32'h3;
            end
        join
        check("ovr_first_text", got, {"00000001", 8'h0D, 8'h0A});
        step();
        check("ovr_done_busy", {79'd0, busy}, 80'd1);
        rx_msg(3, got, lat, ok);
        check("ovr_b2b_latency", 80'(lat), 80'd1);
        check("ovr_second_text", got, {"00000003", 8'h0D, 8'h0A});
        check("ovr_flag", {79'd0, overrun}, 80'd1);
        step();
        step();
        check("ovr_no_third", {79'd0, busy}, 80'd0);

        dr = 32'hA5A55A5A;
        step();
        check("rst_start_bit", {79'd0, txd}, 80'd0);
        repeat (140) step();
        reset = 1'b0;
        step();
        check("rst_txd", {79'd0, txd}, 80'd1);
        check("rst_busy", {79'd0, busy}, 80'd0);
        check("rst_ovr", {79'd0, overrun}, 80'd0);
        step();
        reset = 1'b1;
        rx_msg(5, got, lat, ok);
        check("rst_resend_lat", 80'(lat), 80'd1);
        check("rst_resend_text", got, {"A5A55A5A", 8'h0D, 8'h0A});
        check("rst_resend_frame", {79'd0, ok}, 80'd1);

        repeat (4000) begin
            step();
            if ($urandom_range(0, 199) == 0) dr = $urandom;
            resend = ($urandom_range(0, 299) == 0);
        end
        resend = 1'b0;
        wait_idle();
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dr_uart_reporter.md
Name: dr_uart_reporter

Overview:
- Downstream consumer of the CPU debug register `dr`, which is updated by CPDR.
- Watches `dr` for changes and serialises each new value as ASCII hex text over a UART TX line: 8 uppercase hex digits, MSB nibble first, then CR LF.
- Gives a host terminal a live trace of CPDR output without halting the core.
- Sits beside the CPU top and connects only to `dr` and the board TX pin.

Parameters:
- BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- dr  input  32  CPU debug register value; level signal, no strobe.
- resend  input  1  single-cycle pulse: re-transmit the current `dr` even if unchanged.
- txd  output  1  UART TX line, 8N1, idle high.
- busy  output  1  high while a message is being transmitted.
- overrun  output  1  sticky: a pending value was overwritten before it was sent.

Behaviour:
- Reset (reset==0 at a posedge):
  - txd=1, busy=0, overrun=0.
  - last_sent=32'h0, pending_valid=0, FSM=IDLE, baud counter=0.
  - Reset takes effect mid-frame too: txd is 1 from the next cycle and any partial message is abandoned.
- Change detect, evaluated each cycle:
  - trigger = (dr != last_sent) || resend.
  - Because last_sent resets to 0, a dr of 0 after reset sends nothing.
- Capture when FSM==IDLE and trigger:
  - snapshot<=dr, last_sent<=dr, busy<=1, FSM<=SEND.
  - The start bit (txd=0) appears on the cycle after capture.
- Capture while busy and trigger:
  - pending<=dr, pending_valid<=1, last_sent<=dr.
  - If pending_valid was already 1, overrun<=1. The buffer is a single slot; the latest value wins.
- Message format: 10 bytes.
  - Bytes 0..7: hex digit of snapshot[31-4k -: 4]. 0-9 map to 8'h30+n; A-F map to 8'h41+(n-10).
  - Byte 8 = 8'h0D, byte 9 = 8'h0A.
- Byte framing:
  - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds txd for exactly BAUD_DIV cycles.
  - No idle gap between bytes: the next start bit follows the stop bit immediately.
  - One message lasts 100*BAUD_DIV cycles.
- FSM: IDLE -> SEND (byte index 0..9) -> DONE -> IDLE.
  - DONE lasts one cycle.
  - If pending_valid: snapshot<=pending, pending_valid<=0, and go back to SEND without passing through IDLE. busy stays 1 and the start bit follows on the next cycle.
  - Otherwise busy<=0 and FSM<=IDLE.
- Simultaneous events:
  - trigger in the DONE cycle is treated as "while busy"; that value is loaded at the same DONE transition.
  - resend with dr unchanged while busy still queues into pending.
- overrun clears only on reset.
- txd is driven from a register and is glitch-free.

Decomposition:
- Shared constants go in def.v: ASCII_CR, ASCII_LF, and the state encodings DRTX_IDLE, DRTX_SEND, DRTX_DONE, added alongside the existing `STATE_*` style.
- Sub-module uart_tx_byte(clk, reset, data[7:0], valid, ready, txd), parameterised by BAUD_DIV:
  - Contains the baud counter and the 10-bit shifter.
  - ready is high in its idle state; it accepts on valid&&ready.
  - The next byte is presented in the same cycle as the stop bit's final count, so no gap appears between bytes.
- The reporter owns change detection, the pending slot, the hex nibble-to-ASCII encoder and the byte sequencer.

Test Plan (BAUD_DIV=4):
- Hold reset low for 3 cycles with dr=32'h0, then release and wait 500 cycles -> txd stays 1, busy=0, no start bit.
- Set dr=32'h1234ABCD -> start bit one cycle later. The decoded bytes are 31 32 33 34 41 42 43 44 0D 0A. Each bit lasts 4 cycles, the total is 400 cycles, and busy falls in the cycle after the last stop bit.
- While the message for 32'h00000001 is in flight, set dr=32'h2 and then 32'h3 -> the next message is "00000003\r\n" sent back-to-back with busy continuously high, overrun=1, and 32'h2 is never sent.
- Leave dr=32'hDEADBEEF idle after it has been sent, then pulse resend -> "DEADBEEF\r\n" is transmitted again and overrun stays 0.
- Assert reset in the middle of byte 3 of a message -> txd=1 on the next cycle, busy=0, overrun=0. After release, dr equal to the old value still triggers a send, because last_sent was cleared to 0.
- Change dr in the DONE cycle of a message -> the new value starts immediately with no IDLE cycle, and overrun is unchanged.
